// File: rtl/pin_entry_ctrl.sv
// ============================================================================
// pin_entry_ctrl : keypad PIN collector with submit/verdict handshake and lockout
// Revision 1.0
// ============================================================================
`default_nettype none

module pin_entry_ctrl #(
  parameter int TIMEOUT_CYC = 1000,
  parameter int LOCK_CYC    = 5000,
  parameter int MAX_TRIES   = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        result_valid,
  input  logic        pin_ok,
  output logic [15:0] pin,
  output logic        pin_valid,
  output logic [2:0]  digit_count,
  output logic        busy,
  output logic        accepted,
  output logic        locked,
  output logic [1:0]  fail_cnt
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int LW = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;
  // Timers count to N-1 so the terminal value always fits in $clog2(N) bits.
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCK_CYC - 1);
  localparam logic [2:0]    TRIES     = 3'(MAX_TRIES);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ENTRY    = 3'd1,
    S_SUBMIT   = 3'd2,
    S_WAIT_RES = 3'd3,
    S_LOCKED   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   acc_q, acc_d;
  logic [15:0]   pin_q, pin_d;
  logic          pin_valid_q, pin_valid_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          accepted_q, accepted_d;
  logic          locked_q, locked_d;
  logic [1:0]    fail_q, fail_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [LW-1:0] lock_q, lock_d;

  logic       key_digit, key_clr, key_ent;
  logic [2:0] fail_sum;
  logic       fail_lock;

  assign key_digit = key_valid && (key_code <= 4'd9);
  assign key_clr   = key_valid && (key_code == 4'd10);
  assign key_ent   = key_valid && (key_code == 4'd11);
  assign fail_sum  = {1'b0, fail_q} + 3'd1;
  assign fail_lock = (fail_sum >= TRIES);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    pin_d       = pin_q;
    pin_valid_d = 1'b0;
    cnt_d       = cnt_q;
    accepted_d  = accepted_q;
    fail_d      = fail_q;
    tmr_d       = tmr_q;
    lock_d      = lock_q;

    case (state_q)
      S_IDLE: begin
        if (key_digit) begin
          acc_d      = {12'd0, key_code};
          cnt_d      = 3'd1;
          accepted_d = 1'b0;
          tmr_d      = '0;
          state_d    = S_ENTRY;
        end
      end

      S_ENTRY: begin
        if (key_valid) begin
          tmr_d = '0;
          if (key_digit) begin
            if (cnt_q < 3'd4) begin
              acc_d = acc_q * 16'd10 + {12'd0, key_code};
              cnt_d = cnt_q + 3'd1;
            end
          end else if (key_clr) begin
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_IDLE;
          end else if (key_ent) begin
            if (cnt_q == 3'd4) begin
              pin_d       = acc_q;
              pin_valid_d = 1'b1;
              state_d     = S_SUBMIT;
            end else begin
              acc_d   = '0;
              cnt_d   = '0;
              fail_d  = fail_sum[1:0];
              lock_d  = LOCK_LOAD;
              state_d = fail_lock ? S_LOCKED : S_IDLE;
            end
          end
        end else if (tmr_q == TMO_LAST) begin
          acc_d   = '0;
          cnt_d   = '0;
          tmr_d   = '0;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      S_SUBMIT: begin
        tmr_d   = '0;
        state_d = S_WAIT_RES;
      end

      S_WAIT_RES: begin
        if (result_valid && pin_ok) begin
          acc_d      = '0;
          cnt_d      = '0;
          accepted_d = 1'b1;
          fail_d     = '0;
          state_d    = S_IDLE;
        end else if (result_valid || (tmr_q == TMO_LAST)) begin
          acc_d   = '0;
          cnt_d   = '0;
          tmr_d   = '0;
          fail_d  = fail_sum[1:0];
          lock_d  = LOCK_LOAD;
          state_d = fail_lock ? S_LOCKED : S_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      S_LOCKED: begin
        if (lock_q == '0) begin
          fail_d  = '0;
          state_d = S_IDLE;
        end else begin
          lock_d = lock_q - 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d   = (state_d == S_SUBMIT) || (state_d == S_WAIT_RES);
    locked_d = (state_d == S_LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      pin_q       <= '0;
      pin_valid_q <= 1'b0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      accepted_q  <= 1'b0;
      locked_q    <= 1'b0;
      fail_q      <= '0;
      tmr_q       <= '0;
      lock_q      <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      pin_q       <= pin_d;
      pin_valid_q <= pin_valid_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      accepted_q  <= accepted_d;
      locked_q    <= locked_d;
      fail_q      <= fail_d;
      tmr_q       <= tmr_d;
      lock_q      <= lock_d;
    end
  end

  assign pin         = pin_q;
  assign pin_valid   = pin_valid_q;
  assign digit_count = cnt_q;
  assign busy        = busy_q;
  assign accepted    = accepted_q;
  assign locked      = locked_q;
  assign fail_cnt    = fail_q;

endmodule

`default_nettype wire

// File: doc/pin_entry_ctrl.md
PIN_ENTRY_CTRL -- requirements
Module: pin_entry_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1000: idle-key and result-wait timeout, in clocks.
REQ-002 Parameter LOCK_CYC, default 5000: lockout duration, in clocks.
REQ-003 Parameter MAX_TRIES, default 3: consecutive failures that trigger lockout.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 key_valid  input  1  one-cycle keypad strobe.
REQ-007 key_code  input  4  0-9 digit; 10 clear; 11 enter; 12-15 ignored.
REQ-008 result_valid  input  1  one-cycle strobe from the start checker carrying a verdict.
REQ-009 pin_ok  input  1  verdict, sampled only when result_valid=1.
REQ-010 pin  output  16  submitted PIN as a binary value 0-9999, in the same format the start checker's pin input expects.
REQ-011 pin_valid  output  1  one-cycle strobe marking a new pin.
REQ-012 digit_count  output  3  number of digits entered, 0-4.
REQ-013 busy  output  1  high in SUBMIT and WAIT_RES.
REQ-014 accepted  output  1  high after a successful verdict.
REQ-015 locked  output  1  high in LOCKED.
REQ-016 fail_cnt  output  2  consecutive failures.

Function
REQ-017 The FSM states SHALL be IDLE, ENTRY, SUBMIT, WAIT_RES and LOCKED.
REQ-018 IDLE, digit d: acc=d, digit_count=1, accepted cleared, next state ENTRY. Clear and enter are ignored in IDLE.
REQ-019 ENTRY, digit d with digit_count<4: acc=acc*10+d (16-bit), digit_count incremented. Digits arriving when digit_count=4 are discarded.
REQ-020 ENTRY, clear: acc=0, digit_count=0, next state IDLE, fail_cnt unchanged.
REQ-021 ENTRY, enter with digit_count=4: next state SUBMIT.
REQ-022 ENTRY, enter with digit_count<4: counts as one failure (REQ-026 rules apply); acc and digit_count cleared.
REQ-023 ENTRY, no key_valid for TIMEOUT_CYC consecutive clocks: return to IDLE, acc and count cleared, no failure counted. The idle timer restarts on every key_valid.
REQ-024 SUBMIT (exactly one cycle): pin<=acc and pin_valid=1 in that cycle, then WAIT_RES. pin holds its value until the next SUBMIT.
REQ-025 WAIT_RES, result_valid with pin_ok=1: accepted=1, fail_cnt=0, acc and count cleared, next state IDLE.
REQ-026 WAIT_RES, result_valid with pin_ok=0, or no result within TIMEOUT_CYC: fail_cnt incremented; next state LOCKED if fail_cnt reaches MAX_TRIES, otherwise IDLE.
REQ-027 Keys arriving in SUBMIT, WAIT_RES or LOCKED SHALL be dropped, including a key coincident with result_valid. result_valid outside WAIT_RES is ignored.
REQ-028 LOCKED: locked=1; the down-counter loads LOCK_CYC on entry. At expiry: fail_cnt=0, locked=0, next state IDLE.
REQ-029 accepted stays high until the next digit is entered or reset.
REQ-030 Timer widths SHALL be sized by $clog2 of their parameter. Timers SHALL NOT wrap; they saturate at terminal count.

Reset
REQ-031 rst_n=0 asynchronously forces state IDLE and clears acc, pin, pin_valid, digit_count, busy, accepted, locked, fail_cnt and all timers to 0.
REQ-032 Reset asserted mid-entry or mid-lockout SHALL abandon the operation with no strobe emitted. The first clock edge after release is evaluated in IDLE.

Verification
REQ-033 Keys 9,9,9,9,enter; then result_valid=1 with pin_ok=1 three cycles later -> pin_valid exactly one cycle, pin=9999, busy high until the verdict, then accepted=1 and fail_cnt=0.
REQ-034 Keys 1,8,1,6,7,enter -> fifth digit discarded, pin=1816, digit_count saturated at 4.
REQ-035 Three cycles of 2,6,7,9,enter, each answered pin_ok=0 -> fail_cnt=1,2, then locked=1. A key during lockout is dropped. After 5000 clocks locked=0 and fail_cnt=0.
REQ-036 Keys 1,2,clear, then 5,5,5,5,enter -> pin=5555. Separately, keys 1,2,enter -> fail_cnt=1 and no pin_valid.
REQ-037 Keys 4,4,4,4, then 1000 idle clocks -> back to IDLE with digit_count=0 and fail_cnt unchanged. Separately, a submit with no result for 1000 clocks -> fail_cnt incremented.
REQ-038 rst_n pulsed low mid-LOCKED and mid-ENTRY -> every output is 0 immediately (asynchronous); keys 3,3,3,3,enter afterwards -> normal submit with pin=3333.
